// File: rtl/dsp_mac_sequencer_if.sv
// Bundle of the three buses around the MAC sequencer.
//   in_*    : operand stream (valid/ready), driven by the producer
//   slice_* : connection to the DSP48A1-style slice (A/B/opmode out, P back)
//   res_*   : 48-bit dot-product result (valid/ready), consumed downstream
// master = sequencer side, slave = environment side (producer, slice, consumer).
interface dsp_mac_sequencer_if;
   logic [17:0] in_a;
   logic [17:0] in_b;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] slice_a;
   logic [17:0] slice_b;
   logic [7:0]  slice_op;
   logic [47:0] slice_p;
   logic [47:0] res_data;
   logic        res_valid;
   logic        res_ready;

   modport master (
      input  in_a, in_b, in_valid,
      output in_ready,
      output slice_a, slice_b, slice_op,
      input  slice_p,
      output res_data, res_valid,
      input  res_ready
   );

   modport slave (
      output in_a, in_b, in_valid,
      input  in_ready,
      input  slice_a, slice_b, slice_op,
      output slice_p,
      input  res_data, res_valid,
      output res_ready
   );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Dot-product controller for a DSP48A1-style slice (A1REG=B1REG=1, MREG=1,
// PREG=1, OPMODEREG=1). Streams LEN operand pairs into the slice, tags each
// issued slot so the opmode reaches the slice in step with the multiplier
// output, waits for the P pipeline to drain and returns P as one result.
// Ports:
//   clk   : clock, rising edge
//   RSTN  : asynchronous reset, active low
//   bus   : dsp_mac_sequencer_if.master (operand in, slice drive, result out)
module dsp_mac_sequencer #(
   parameter int unsigned LEN     = 8,
   parameter int unsigned MUL_LAT = 2
) (
   input logic                 clk,
   input logic                 RSTN,
   dsp_mac_sequencer_if.master bus
);

   localparam int unsigned CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int unsigned DRN_W  = $clog2(MUL_LAT + 2);
   localparam int unsigned PIPE_D = MUL_LAT - 1;

   localparam logic [7:0] OP_RESTART = 8'h01;  // X=M, Z=0
   localparam logic [7:0] OP_ACC     = 8'h09;  // X=M, Z=P
   localparam logic [7:0] OP_HOLD    = 8'h08;  // X=0, Z=P

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_term_cnt;
   logic [DRN_W-1:0]   r_drain_cnt;
   logic [PIPE_D-1:0]  r_tag_v;
   logic [PIPE_D-1:0]  r_tag_f;
   logic               r_in_ready;
   logic [17:0]        r_slice_a;
   logic [17:0]        r_slice_b;
   logic [7:0]         r_slice_op;
   logic [47:0]        r_res_data;
   logic               r_res_valid;

   logic               w_accept;
   logic               w_first;
   logic               w_last;
   logic [7:0]         w_op;

   assign w_accept = (r_state == S_LOAD) && bus.in_valid && r_in_ready;
   assign w_first  = (r_term_cnt == '0);
   assign w_last   = (r_term_cnt == CNT_W'(LEN - 1));

   // Opmode for the slot leaving the tag delay line; idle/done states hold P.
   always_comb begin
      w_op = OP_HOLD;
      if (r_state != S_IDLE && r_state != S_DONE && r_tag_v[PIPE_D-1]) begin
         w_op = r_tag_f[PIPE_D-1] ? OP_RESTART : OP_ACC;
      end
   end

   // Sequencer state, slot issue, tag delay line and result capture.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         r_state     <= S_IDLE;
         r_term_cnt  <= '0;
         r_drain_cnt <= '0;
         r_tag_v     <= '0;
         r_tag_f     <= '0;
         r_in_ready  <= 1'b0;
         r_slice_a   <= '0;
         r_slice_b   <= '0;
         r_slice_op  <= 8'h00;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
      end else begin
         // Every cycle issues a slot: a real pair on accept, otherwise a bubble.
         r_slice_a  <= '0;
         r_slice_b  <= '0;
         r_tag_v[0] <= w_accept;
         r_tag_f[0] <= w_accept && w_first;
         for (int unsigned k = 1; k < PIPE_D; k++) begin
            r_tag_v[k] <= r_tag_v[k-1];
            r_tag_f[k] <= r_tag_f[k-1];
         end
         r_slice_op <= w_op;

         case (r_state)
            S_IDLE: begin
               r_state    <= S_LOAD;
               r_in_ready <= 1'b1;
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_slice_a <= bus.in_a;
                  r_slice_b <= bus.in_b;
                  if (w_last) begin
                     r_term_cnt  <= '0;
                     r_drain_cnt <= '0;
                     r_in_ready  <= 1'b0;
                     r_state     <= S_DRAIN;
                  end else begin
                     r_term_cnt <= r_term_cnt + CNT_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // Last slot needs MUL_LAT+1 edges to land in P; sample P one edge later.
               if (r_drain_cnt == DRN_W'(MUL_LAT + 1)) begin
                  r_drain_cnt <= '0;
                  r_res_data  <= bus.slice_p;
                  r_res_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRN_W'(1);
               end
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_LOAD;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.slice_a   = r_slice_a;
   assign bus.slice_b   = r_slice_b;
   assign bus.slice_op  = r_slice_op;
   assign bus.res_data  = r_res_data;
   assign bus.res_valid = r_res_valid;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: three instances (LEN=4, 1, 2) each wired to a
// behavioural DSP48A1-style slice. Expected dot products are pushed to a queue
// as pairs are driven and popped when a result appears.
module tb_dsp_mac_sequencer;

   localparam int unsigned MUL_LAT = 2;
   localparam int unsigned N       = 3;

   logic        clk = 1'b0;
   logic        rstn;
   always #5 clk = ~clk;

   logic [17:0] t_a      [N];
   logic [17:0] t_b      [N];
   logic        t_valid  [N];
   logic        t_rready [N];
   logic        o_rdy    [N];
   logic [17:0] o_sa     [N];
   logic [17:0] o_sb     [N];
   logic [7:0]  o_op     [N];
   logic [47:0] o_res    [N];
   logic        o_rvalid [N];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          sel = 0;
   logic        log_en = 1'b0;
   logic [7:0]  op_log [$];
   always @(negedge clk) if (log_en) op_log.push_back(o_op[sel]);

   int          errors = 0;
   int          checks = 0;
   logic [47:0] exp_q [$];
   logic [47:0] acc = '0;
   logic [47:0] last_exp = '0;

   for (genvar g = 0; g < N; g++) begin : g_inst
      localparam int unsigned G_LEN = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
      dsp_mac_sequencer_if bus ();
      logic [17:0] s_a1, s_b1;
      logic [35:0] s_m;
      logic [7:0]  s_opr;
      logic [47:0] s_p, s_x, s_z;

      assign bus.in_a      = t_a[g];
      assign bus.in_b      = t_b[g];
      assign bus.in_valid  = t_valid[g];
      assign bus.res_ready = t_rready[g];
      assign bus.slice_p   = s_p;
      assign o_rdy[g]      = bus.in_ready;
      assign o_sa[g]       = bus.slice_a;
      assign o_sb[g]       = bus.slice_b;
      assign o_op[g]       = bus.slice_op;
      assign o_res[g]      = bus.res_data;
      assign o_rvalid[g]   = bus.res_valid;

      dsp_mac_sequencer #(.LEN(G_LEN), .MUL_LAT(MUL_LAT)) u_dut (
         .clk  (clk),
         .RSTN (rstn),
         .bus  (bus)
      );

      // Slice model: A1/B1 regs, M reg, opmode reg, P reg; X = opmode[1:0], Z = opmode[3:2].
      always_comb begin
         s_x = (s_opr[1:0] == 2'b01) ? 48'(s_m) : 48'd0;
         s_z = (s_opr[3:2] == 2'b10) ? s_p : 48'd0;
      end
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opr <= '0; s_p <= '0;
         end else begin
            s_a1  <= bus.slice_a;
            s_b1  <= bus.slice_b;
            s_m   <= 36'(s_a1) * 36'(s_b1);
            s_opr <= bus.slice_op;
            s_p   <= s_z + s_x;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"},  64'(o_rdy[sel]),    64'd0);
      check({tag, "_slice_a"},   64'(o_sa[sel]),     64'd0);
      check({tag, "_slice_b"},   64'(o_sb[sel]),     64'd0);
      check({tag, "_slice_op"},  64'(o_op[sel]),     64'd0);
      check({tag, "_res_data"},  64'(o_res[sel]),    64'd0);
      check({tag, "_res_valid"}, 64'(o_rvalid[sel]), 64'd0);
   endtask

   // Starts and ends just after a rising edge; ready is sampled on the falling edge.
   task automatic send_pair(input logic [17:0] a, input logic [17:0] b);
      logic ok;
      int   n = 0;
      t_a[sel] = a; t_b[sel] = b; t_valid[sel] = 1'b1;
      do begin
         @(negedge clk); ok = o_rdy[sel];
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 40);
      if (!ok) check("send_timeout", 64'd0, 64'd1);
      acc = acc + 48'(a) * 48'(b);
   endtask

   task automatic idle(input int n);
      t_valid[sel] = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic end_product();
      t_valid[sel] = 1'b0;
      exp_q.push_back(acc);
      acc = '0;
   endtask

   task automatic wait_valid(output int unsigned rise);
      int n = 0;
      rise = 0;
      do begin @(negedge clk); n++; end while (!o_rvalid[sel] && n < 60);
      if (o_rvalid[sel]) rise = cyc;
      else check("result_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_result(input string tag);
      if (exp_q.size() == 0) begin
         check({tag, "_no_expected"}, 64'd0, 64'd1);
      end else begin
         last_exp = exp_q.pop_front();
         check(tag, 64'(o_res[sel]), 64'(last_exp));
      end
   endtask

   task automatic hold(input int n);
      t_rready[sel] = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check("hold_res_valid", 64'(o_rvalid[sel]), 64'd1);
         check("hold_res_data",  64'(o_res[sel]),    64'(last_exp));
         check("hold_in_ready",  64'(o_rdy[sel]),    64'd0);
      end
   endtask

   task automatic handshake(input string tag);
      t_rready[sel] = 1'b1;
      @(posedge clk); #1;
      t_rready[sel] = 1'b0;
      check({tag, "_valid_drop"}, 64'(o_rvalid[sel]), 64'd0);
      check({tag, "_ready_back"}, 64'(o_rdy[sel]),    64'd1);
   endtask

   // Finds the first restart opmode in the log and compares n opmodes from there.
   task automatic check_ops(input string tag, input logic [63:0] seq, input int n);
      int idx = -1;
      logic [7:0] e;
      for (int i = 0; i < op_log.size(); i++) begin
         if (idx < 0 && op_log[i] == 8'h01) idx = i;
      end
      if (idx < 0) begin
         check({tag, "_no_restart"}, 64'd0, 64'd1);
      end else begin
         for (int k = 0; k < n; k++) begin
            e = seq[(n-1-k)*8 +: 8];
            if (idx + k < op_log.size()) check($sformatf("%s_op%0d", tag, k), 64'(op_log[idx+k]), 64'(e));
            else check($sformatf("%s_op%0d_missing", tag, k), 64'd0, 64'(e));
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned rise, acc_cyc, hs_cyc;
      rstn = 1'b0;
      for (int i = 0; i < N; i++) begin
         t_a[i] = '0; t_b[i] = '0; t_valid[i] = 1'b0; t_rready[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int s = 0; s < N; s++) begin sel = s; check_zero("reset"); end
      rstn = 1'b1;
      @(posedge clk); #1;

      // 1: basic LEN=4 product and latency
      sel = 0; acc = '0;
      send_pair(1, 2); send_pair(3, 4); send_pair(5, 6); send_pair(7, 8);
      acc_cyc = cyc;
      end_product();
      wait_valid(rise);
      check("t1_latency", 64'(rise - acc_cyc), 64'(MUL_LAT + 2));
      check_result("t1_result");
      handshake("t1");

      // 2: three bubbles between pairs 2 and 3
      op_log.delete(); log_en = 1'b1;
      send_pair(1, 2); send_pair(3, 4); idle(3); send_pair(5, 6); send_pair(7, 8);
      end_product();
      wait_valid(rise);
      check_result("t2_result");
      handshake("t2");
      log_en = 1'b0;
      check_ops("t2", 64'h01_09_08_08_08_09_09_08, 8);

      // 3: result held under backpressure, then back-to-back products
      send_pair(1, 1); send_pair(1, 1); send_pair(1, 1); send_pair(1, 1);
      end_product();
      wait_valid(rise);
      check_result("t3_first");
      hold(10);
      handshake("t3a");
      hs_cyc = cyc;
      send_pair(2, 3);
      check("t3_b2b_accept", 64'(cyc - hs_cyc), 64'd1);
      send_pair(2, 3); send_pair(2, 3); send_pair(2, 3);
      end_product();
      wait_valid(rise);
      check_result("t3_second");
      handshake("t3b");

      // 4: LEN=1 with full-scale operands
      sel = 1; acc = '0;
      op_log.delete(); log_en = 1'b1;
      send_pair(18'h3FFFF, 18'h3FFFF);
      end_product();
      wait_valid(rise);
      check_result("t4_result");
      check("t4_const", 64'(last_exp), 64'd68718952449);
      handshake("t4");
      log_en = 1'b0;
      check_ops("t4", 64'h0108, 2);

      // 5: asynchronous reset during the second term, then a fresh product
      sel = 0; acc = '0;
      send_pair(1, 2);
      t_a[sel] = 3; t_b[sel] = 4; t_valid[sel] = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check_zero("t5_async");
      t_valid[sel] = 1'b0; acc = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      send_pair(1, 2); send_pair(3, 4); send_pair(5, 6); send_pair(7, 8);
      end_product();
      wait_valid(rise);
      check_result("t5_result");
      handshake("t5");

      // 6: LEN=2, zero product after a nonzero one
      sel = 2; acc = '0;
      send_pair(3, 5); send_pair(2, 2);
      end_product();
      wait_valid(rise);
      check_result("t6_prior");
      handshake("t6a");
      send_pair(0, 5); send_pair(0, 0);
      end_product();
      wait_valid(rise);
      check_result("t6_zero");
      handshake("t6b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
